// File: rtl/matmul_sequencer.sv
// Sequences C = A x B: walks (i, j, k) with k innermost, issues one A/B read per
// cycle and drives the MAC enable/first strobes and the result-memory write.
module matmul_sequencer #(
  parameter int DIM_W  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  r1,
  input  logic [DIM_W-1:0]  c1,
  input  logic [DIM_W-1:0]  r2,
  input  logic [DIM_W-1:0]  c2,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // All outputs are plain strobes (no handshake): the MAC and memories must
  // accept every cycle that rd_en / mac_en / res_we is high.
  typedef struct packed {
    state_t            state;
    logic [DIM_W-1:0]  r1;
    logic [DIM_W-1:0]  c1;
    logic [DIM_W-1:0]  c2;
    logic [DIM_W-1:0]  i;
    logic [DIM_W-1:0]  j;
    logic [DIM_W-1:0]  k;
    logic              drain;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] res_ptr;
    logic              rd_en;
    logic              mac_en;
    logic              mac_first;
    logic              s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic              res_we;
    logic [ADDR_W-1:0] res_addr;
    logic              busy;
    logic              done;
    logic              err;
  } regs_t;

  localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  regs_t regs_q, regs_d;

  logic [DIM_W-1:0]  r1_m1, c1_m1, c2_m1;
  logic [ADDR_W-1:0] c1_ext, c2_ext;
  logic              shape_bad;

  assign r1_m1     = regs_q.r1 - ONE_D;
  assign c1_m1     = regs_q.c1 - ONE_D;
  assign c2_m1     = regs_q.c2 - ONE_D;
  assign c1_ext    = ADDR_W'(regs_q.c1);
  assign c2_ext    = ADDR_W'(regs_q.c2);
  assign shape_bad = (c1 != r2) || (r1 == '0) || (c1 == '0) || (r2 == '0) || (c2 == '0);

  always_comb begin
    regs_d           = regs_q;
    regs_d.rd_en     = 1'b0;
    regs_d.done      = 1'b0;
    // Stage 1 tags each read; stage 2 writes the element after its last k term.
    regs_d.mac_en    = regs_q.rd_en;
    regs_d.mac_first = regs_q.rd_en && (regs_q.k == '0);
    regs_d.s1_last   = regs_q.rd_en && (regs_q.k == c1_m1);
    regs_d.s1_addr   = regs_q.res_ptr;
    regs_d.res_we    = regs_q.mac_en && regs_q.s1_last;
    regs_d.res_addr  = (regs_q.mac_en && regs_q.s1_last) ? regs_q.s1_addr : '0;

    case (regs_q.state)
      S_IDLE: begin
        if (start) begin
          regs_d.r1  = r1;
          regs_d.c1  = c1;
          regs_d.c2  = c2;
          regs_d.err = 1'b0;
          if (shape_bad) begin
            regs_d.err = 1'b1;
          end else begin
            regs_d.state   = S_RUN;
            regs_d.rd_en   = 1'b1;
            regs_d.busy    = 1'b1;
            regs_d.i       = '0;
            regs_d.j       = '0;
            regs_d.k       = '0;
            regs_d.a_base  = '0;
            regs_d.a_addr  = '0;
            regs_d.b_addr  = '0;
            regs_d.res_ptr = '0;
          end
        end
      end
      S_RUN: begin
        if (regs_q.k != c1_m1) begin
          regs_d.rd_en  = 1'b1;
          regs_d.k      = regs_q.k + ONE_D;
          regs_d.a_addr = regs_q.a_addr + ONE_A;
          regs_d.b_addr = regs_q.b_addr + c2_ext;
        end else if (regs_q.j != c2_m1) begin
          regs_d.rd_en   = 1'b1;
          regs_d.k       = '0;
          regs_d.j       = regs_q.j + ONE_D;
          regs_d.a_addr  = regs_q.a_base;
          regs_d.b_addr  = ADDR_W'(regs_q.j) + ONE_A;
          regs_d.res_ptr = regs_q.res_ptr + ONE_A;
        end else if (regs_q.i != r1_m1) begin
          regs_d.rd_en   = 1'b1;
          regs_d.k       = '0;
          regs_d.j       = '0;
          regs_d.i       = regs_q.i + ONE_D;
          regs_d.a_base  = regs_q.a_base + c1_ext;
          regs_d.a_addr  = regs_q.a_base + c1_ext;
          regs_d.b_addr  = '0;
          regs_d.res_ptr = regs_q.res_ptr + ONE_A;
        end else begin
          regs_d.state = S_DRAIN;
          regs_d.drain = 1'b0;
        end
      end
      S_DRAIN: begin
        if (regs_q.drain) begin
          regs_d.state = S_DONE;
          regs_d.drain = 1'b0;
          regs_d.busy  = 1'b0;
          regs_d.done  = 1'b1;
        end else begin
          regs_d.drain = 1'b1;
        end
      end
      default: begin
        regs_d.state = S_IDLE;
      end
    endcase

    if (abort) begin
      regs_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_en     = regs_q.rd_en;
  assign a_addr    = regs_q.a_addr;
  assign b_addr    = regs_q.b_addr;
  assign mac_en    = regs_q.mac_en;
  assign mac_first = regs_q.mac_first;
  assign res_we    = regs_q.res_we;
  assign res_addr  = regs_q.res_addr;
  assign busy      = regs_q.busy;
  assign done      = regs_q.done;
  assign err       = regs_q.err;
  assign dbg_state = regs_q.state;

endmodule
